// File: rtl/harmonic_scheduler.sv
// rtl/harmonic_scheduler.sv - per-sample harmonic frame sequencer (position RAM, adder, DAC)
// Optional build macro SCHED_FREQ_MONITOR_EN: DAC payload carries the active frequency instead of the sum.
module harmonic_scheduler #(
   parameter int SAMPLE_INTERVAL = 1500,
   parameter int SAMPLE_RATE     = 48000,
   parameter int HARMONICS       = 11,
   parameter int LUT_SHIFT       = 5,
   parameter int MULT_START      = 127,
   parameter int MULT_STEP       = 10,
   parameter int MULT_FLOOR      = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] frequency_in,
   input  logic        frequency_valid,
   output logic [7:0]  sp_addr,
   input  logic [15:0] sp_readdata,
   output logic [15:0] sp_writedata,
   output logic        sp_write,
   output logic [10:0] lut_addr,
   output logic        adder_start,
   output logic        adder_clear,
   output logic [6:0]  adder_mult,
   input  logic        adder_ready,
   input  logic [31:0] adder_total,
   output logic [23:0] dac_data,
   output logic        dac_send,
   output logic        overrun
);
   localparam int              CW         = $clog2(SAMPLE_INTERVAL);
   localparam logic [CW-1:0]   TICK_AT    = CW'(SAMPLE_INTERVAL - 1);
   localparam logic [16:0]     RATE       = 17'(SAMPLE_RATE);
   localparam logic [15:0]     FREQ_MAX   = 16'(SAMPLE_RATE / 2 - 1);
   localparam logic [7:0]      LAST_H     = 8'(HARMONICS - 1);
   localparam logic [6:0]      M_START    = 7'(MULT_START);
   localparam logic [6:0]      M_STEP     = 7'(MULT_STEP);
   localparam logic [6:0]      M_DROP_MIN = 7'(MULT_FLOOR + MULT_STEP);

   typedef enum logic [3:0] {
      S_CLEAR, S_PREP, S_READ, S_CALC, S_WRITE, S_LUTWAIT, S_ISSUE, S_DRAIN, S_READY
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] counter;
   logic          tick;
   logic [15:0]   pending, active, active_d, inc, inc_d;
   logic [7:0]    h, h_d;
   logic [31:0]   sum, sum_d;
   logic          drain_first, drain_first_d, ovr_pend, ovr_pend_d;
   logic [6:0]    mult_d;
   logic [7:0]    sp_addr_d;
   logic [15:0]   sp_writedata_d;
   logic [10:0]   lut_addr_d;
   logic [23:0]   dac_data_d;
   logic          sp_write_d, adder_start_d, adder_clear_d, dac_send_d, overrun_d;
   logic          any_strobe, ovr_req;
   logic [16:0]   pos_raw, pos_wrap, inc_raw, inc_wrap;
   logic [15:0]   pos_shifted;

   assign tick        = counter == TICK_AT;
   assign pos_raw     = {1'b0, sp_readdata} + {1'b0, inc};
   assign pos_wrap    = (pos_raw >= RATE) ? pos_raw - RATE : pos_raw;
   assign inc_raw     = {1'b0, inc} + {1'b0, active};
   assign inc_wrap    = (inc_raw >= RATE) ? inc_raw - RATE : inc_raw;
   assign pos_shifted = pos_wrap[15:0] >> LUT_SHIFT;

   // Outputs are registered from their next values so each is valid during the state it belongs to.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_CLEAR;
         counter      <= '0;
         pending      <= 16'd1000;
         active       <= 16'd1000;
         inc          <= '0;
         h            <= '0;
         sum          <= '0;
         drain_first  <= 1'b0;
         ovr_pend     <= 1'b0;
         adder_mult   <= M_START;
         sp_addr      <= '0;
         sp_writedata <= '0;
         sp_write     <= 1'b0;
         lut_addr     <= '0;
         adder_start  <= 1'b0;
         adder_clear  <= 1'b0;
         dac_data     <= '0;
         dac_send     <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         counter <= tick ? '0 : counter + 1'b1;
         if (frequency_valid)
            pending <= (frequency_in > FREQ_MAX) ? FREQ_MAX : frequency_in;
         state        <= state_d;
         active       <= active_d;
         inc          <= inc_d;
         h            <= h_d;
         sum          <= sum_d;
         drain_first  <= drain_first_d;
         ovr_pend     <= ovr_pend_d;
         adder_mult   <= mult_d;
         sp_addr      <= sp_addr_d;
         sp_writedata <= sp_writedata_d;
         sp_write     <= sp_write_d;
         lut_addr     <= lut_addr_d;
         adder_start  <= adder_start_d;
         adder_clear  <= adder_clear_d;
         dac_data     <= dac_data_d;
         dac_send     <= dac_send_d;
         overrun      <= overrun_d;
      end
   end

   always_comb begin
      state_d       = state;
      active_d      = active;
      inc_d         = inc;
      h_d           = h;
      sum_d         = sum;
      drain_first_d = drain_first;
      mult_d        = adder_mult;
      // The scale steps down while the just-issued start is visible, so the adder sees a stable value.
      if (adder_start && adder_mult >= M_DROP_MIN)
         mult_d = adder_mult - M_STEP;
      case (state)
         S_CLEAR: begin
            h_d = h + 8'd1;
            if (h == LAST_H) begin
               h_d     = '0;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            active_d = pending;
            inc_d    = pending;
            h_d      = '0;
            mult_d   = M_START;
            state_d  = S_READ;
         end
         S_READ:    state_d = S_CALC;
         S_CALC:    state_d = S_WRITE;
         S_WRITE: begin
            inc_d   = inc_wrap[15:0];
            state_d = S_LUTWAIT;
         end
         S_LUTWAIT: state_d = S_ISSUE;
         S_ISSUE: begin
            if (adder_ready) begin
               h_d           = h + 8'd1;
               drain_first_d = 1'b1;
               state_d       = (h == LAST_H) ? S_DRAIN : S_READ;
            end
         end
         S_DRAIN: begin
            drain_first_d = 1'b0;
            if (!drain_first && adder_ready) begin
               sum_d   = adder_total + 32'h1FFFF;
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (tick)
               state_d = S_PREP;
         end
         default:   state_d = S_CLEAR;
      endcase
   end

   always_comb begin
      sp_addr_d      = sp_addr;
      sp_writedata_d = sp_writedata;
      lut_addr_d     = lut_addr;
      dac_data_d     = dac_data;
      sp_write_d     = 1'b0;
      adder_start_d  = 1'b0;
      adder_clear_d  = 1'b0;
      dac_send_d     = 1'b0;
      case (state)
         S_CLEAR: begin
            sp_write_d     = 1'b1;
            sp_addr_d      = h;
            sp_writedata_d = '0;
         end
         S_PREP: begin
            adder_clear_d = 1'b1;
            sp_addr_d     = '0;
         end
         S_CALC: begin
            sp_write_d     = 1'b1;
            sp_writedata_d = pos_wrap[15:0];
            lut_addr_d     = pos_shifted[10:0];
         end
         S_ISSUE: begin
            if (adder_ready) begin
               adder_start_d = 1'b1;
               sp_addr_d     = h + 8'd1;
            end
         end
         S_READY: begin
            if (tick) begin
               dac_send_d = 1'b1;
`ifdef SCHED_FREQ_MONITOR_EN
               dac_data_d = {8'h31, active};
`else
               dac_data_d = {8'h31, sum[17:2]};
`endif
            end
         end
         default: ;
      endcase
      // A late-frame overrun waits for a cycle free of other strobes so no two pulses overlap.
      any_strobe = sp_write_d | adder_start_d | adder_clear_d | dac_send_d;
      ovr_req    = ovr_pend | (tick && state != S_READY);
      overrun_d  = ovr_req & ~any_strobe;
      ovr_pend_d = ovr_req & any_strobe;
   end
endmodule

// File: doc/harmonic_scheduler.md
HARMONIC_SCHEDULER -- requirements
Module: harmonic_scheduler

Interface
REQ-001 SHALL have parameters: SAMPLE_INTERVAL, 1500, clocks per output sample; SAMPLE_RATE, 48000, phase modulus; HARMONICS, 11, harmonics per frame; LUT_SHIFT, 5, position-to-LUT shift; MULT_START, 127, first-harmonic scale; MULT_STEP, 10, per-harmonic scale decrement; MULT_FLOOR, 10, minimum scale.
REQ-002 SHALL have these ports (name, direction, width, meaning): clock in 1 system clock; reset in 1 asynchronous active-high reset; frequency_in in 16 new fundamental frequency; frequency_valid in 1 strobe qualifying frequency_in; sp_addr out 8 position RAM address; sp_readdata in 16 RAM read data, registered, 1-cycle latency; sp_writedata out 16 RAM write data; sp_write out 1 RAM write enable; lut_addr out 11 sine LUT address, 2-cycle latency; adder_start out 1 accumulate strobe; adder_clear out 1 accumulator clear; adder_mult out 7 scale; adder_ready in 1 adder idle; adder_total in 32 signed accumulated sum; dac_data out 24 DAC word; dac_send out 1 DAC send strobe; overrun out 1 frame-late pulse.
REQ-003 SHALL use one clock, clock; reset is asynchronous and active-high, named reset.

Function
REQ-004 SHALL run a free-running sample counter 0..SAMPLE_INTERVAL-1 and raise the internal tick when the count equals SAMPLE_INTERVAL-1.
REQ-005 SHALL capture frequency_in into a pending register on any cycle with frequency_valid=1, clamped to SAMPLE_RATE/2-1 (23999) if larger; the last strobe before PREP wins.
REQ-006 SHALL implement states CLEAR, PREP, READ, CALC, WRITE, LUTWAIT, ISSUE, DRAIN, READY.
REQ-007 CLEAR: write 0 to addresses 0..HARMONICS-1, one per cycle, with sp_write=1; then go to PREP.
REQ-008 PREP (1 cycle): pulse adder_clear, copy pending to active frequency, set h=0, inc=active frequency, and adder_mult=MULT_START; then go to READ.
REQ-009 READ: drive sp_addr=h with sp_write=0; then go to CALC.
REQ-010 CALC: pos = sp_readdata+inc, computed in 17 bits, minus SAMPLE_RATE if >= SAMPLE_RATE; then go to WRITE.
REQ-011 WRITE: sp_write=1, sp_writedata=pos, lut_addr=pos>>LUT_SHIFT, inc=(inc+active frequency) mod SAMPLE_RATE by single conditional subtract; then go to LUTWAIT.
REQ-012 LUTWAIT: 1 cycle, sp_write=0; then go to ISSUE.
REQ-013 ISSUE: hold until adder_ready=1, then pulse adder_start for exactly 1 cycle and increment h. If h reaches HARMONICS, go to DRAIN; else go to READ.
REQ-014 After each ISSUE, adder_mult SHALL drop by MULT_STEP when that keeps it >= MULT_FLOOR; otherwise it holds.
REQ-015 DRAIN: ignore adder_ready in the first cycle, then wait for adder_ready=1, form sum=adder_total+32'h1FFFF, and go to READY.
REQ-016 READY: on tick, set dac_data={8'h31, sum[17:2]}, pulse dac_send for 1 cycle, and go to PREP.
REQ-017 A tick occurring outside READY SHALL pulse overrun for 1 cycle; the frame completes and sends on the next tick; the counter never stalls.
REQ-018 Frequency 0 SHALL leave all stored positions unchanged while frames still run and send.
REQ-019 adder_start, adder_clear, sp_write, dac_send, and overrun SHALL be single-cycle pulses, never asserted simultaneously with each other except sp_write during CLEAR.

Reset
REQ-020 On reset, the block SHALL immediately set: state=CLEAR, h=0, counter=0, pending and active frequency=1000, inc=0, adder_mult=MULT_START, lut_addr=0, sp_addr=0, sp_writedata=0, dac_data=0, and all strobes=0.
REQ-021 Reset mid-frame SHALL abandon the frame with no dac_send; CLEAR re-zeros all positions.

Configuration
REQ-022 With SCHED_FREQ_MONITOR_EN defined, the dac_data payload SHALL be {8'h31, active frequency}; without it, the payload is per REQ-016. Timing is identical in both cases.

Verification
REQ-023 Reset release: 11 sp_write pulses to addresses 0..10 with data 0, then one adder_clear pulse.
REQ-024 Frequency 1000, adder always ready: stored positions after frame 1 are 1000·k for harmonic k=1..11; adder_mult sequence is 127,117,...,27; exactly 11 adder_start pulses.
REQ-025 Frequency 30000 strobed: clamped to 23999; harmonic 3 stored position is 71997-48000=23997 after frame 1.
REQ-026 Hold adder_ready low for 2000 cycles mid-frame: one overrun pulse; dac_send occurs on the next tick; the counter period stays 1500.
REQ-027 adder_total=0: dac_data=24'h317FFF; with SCHED_FREQ_MONITOR_EN defined and frequency 1000: dac_data=24'h3103E8.
REQ-028 Assert reset during ISSUE of harmonic 5: no dac_send, and CLEAR restarts from address 0.
